lfo_dac_tx: RTL and testbench
=============================

// Module: lfo_dac_tx
// PURPOSE
//  Consumes the 10-bit modulation samples produced at the sample rate by the LFO/oscillator blocks.
//  Serialises each sample as one 16-bit SPI write frame to an external 10-bit DAC (MCP4911-style).
//  Includes a 1-deep pending buffer so a sample arriving mid-frame is not lost.
//  Sits between the waveform generators and the board's analog CV output.
// PARAMETERS
//  CLK_DIV   4        clk cycles per SCLK half-period (>=2); 24 MHz/8 = 3 MHz SCLK
//  CFG_BITS  4'b0011  frame bits [15:12]: {A/B, BUF, GA_n, SHDN_n}
//  LDAC_W    2        ldac_n low-pulse width in clk cycles (only with LFO_DAC_LDAC_EN)
// PORTS
//  clk          in   1   system clock (24 MHz)
//  reset_n      in   1   synchronous, active-low reset
//  sample_tick  in   1   one-clk strobe: sample_in valid this cycle
//  sample_in    in   10  unsigned sample (0 = min, 1023 = max)
//  sclk         out  1   SPI clock, mode 0 (idles low, DAC samples on rising edge)
//  mosi         out  1   SPI data, MSB first
//  cs_n         out  1   DAC chip select, active low
//  ldac_n       out  1   DAC latch strobe, active low (tied 1 without LFO_DAC_LDAC_EN)
//  busy         out  1   1 while a frame is in progress (any state other than IDLE)
//  overrun      out  1   sticky: a pending sample was overwritten; cleared only by reset
// BEHAVIOUR
//  Reset (reset_n=0 at a rising clk edge): state=IDLE, sclk=0, mosi=0, cs_n=1, ldac_n=1,
//   busy=0, overrun=0, pending buffer empty. Reset mid-frame aborts the frame immediately
//   (cs_n high on the next edge); the DAC discards the partial frame.
//  Frame = {CFG_BITS, sample[9:0], 2'b00}, 16 bits, shifted out MSB first.
//  FSM: IDLE -> SHIFT -> HOLD -> GAP -> (LDAC) -> IDLE or SHIFT.
//   IDLE:  on sample_tick at edge N, load the frame; at N+1: cs_n=0, mosi=bit15, busy=1.
//   SHIFT: each bit lasts 2*CLK_DIV cycles: CLK_DIV cycles with sclk=0, then CLK_DIV with sclk=1.
//          mosi changes only on the high->low transition of sclk (and at frame start).
//          The phase counter runs 0..CLK_DIV-1 and is $clog2(CLK_DIV) bits wide.
//   HOLD:  after bit0's high phase, sclk=0 and cs_n stays 0 for CLK_DIV cycles.
//   GAP:   cs_n=1 for CLK_DIV cycles (minimum CS-high time).
//   Exit:  if pending is full -> SHIFT with the pending sample and clear pending;
//          otherwise -> IDLE.
//  With CLK_DIV=4, cs_n is low for cycles N+1..N+132, and busy=0 at N+137.
//   Worst-case frame = 1+16*2*CLK_DIV+2*CLK_DIV cycles; this is well under 544 clk per 44.1 kHz sample.
//  sample_tick while busy: write sample_in to pending. If pending is already full,
//   overwrite it (newest wins) and set overrun=1.
//  sample_tick on the same edge that pending is consumed: the new sample becomes pending;
//   overrun is not set.
//  Edge cases: sample 0 -> frame 0x3000; sample 1023 -> frame 0x3FFC (no saturation or clip).
// CONFIGURATION
//  LFO_DAC_LDAC_EN defined:
//   - After GAP, an LDAC state drives ldac_n=0 for LDAC_W cycles, then ldac_n=1 for 1 cycle.
//   - The next state is then chosen as in Exit.
//   - The DAC output updates only on the ldac_n pulse (glitch-free, sample-aligned).
//  LFO_DAC_LDAC_EN undefined:
//   - There is no LDAC state; ldac_n is held at constant 1.
//   - The DAC is expected to have its LDAC pin strapped low, so it updates on the cs_n rise.
// STRUCTURE
//  synth_pkg (shared header): FSM state encodings, FRAME_W=16, SAMPLE_W=10,
//   and frame field offsets (CFG_LSB=12, DATA_LSB=2).
//  Sub-module spi_bit_timer: phase counter plus SCLK generator.
//   - Outputs rise_tick/fall_tick strobes and a bit counter with a last_bit flag.
//   - Reused by the future panel SPI blocks.
//  The FSM, shift register, pending buffer and flags live in lfo_dac_tx.
// TESTING
//  1. Reset, then tick with sample=10'h2AA -> 16 mosi bits captured on sclk rise = 0x3AA8;
//     cs_n low for 132 cycles.
//  2. sample 10'h000 and 10'h3FF -> frames 0x3000 and 0x3FFC; sclk toggles exactly 32 times per frame.
//  3. Tick A, then tick B mid-frame -> B is sent back-to-back after GAP with a CLK_DIV-cycle cs_n high gap;
//     overrun=0.
//  4. Ticks A, B, C with B and C during frame A -> frames A then C; B is dropped; overrun=1 until reset.
//  5. reset_n=0 during bit 7 -> next edge: cs_n=1, sclk=0, busy=0;
//     the next tick produces a clean full frame.
//  6. LFO_DAC_LDAC_EN build: ldac_n low for 2 cycles starting 1 cycle after the GAP ends;
//     never low while cs_n=0. Non-EN build: ldac_n always 1.

Source files
------------

// File: rtl/lfo_dac_tx_pkg.sv
// Shared definitions for the LFO DAC transmitter: FSM state encodings,
// frame geometry and a frame-building helper.
package lfo_dac_tx_pkg;
  localparam int FRAME_W  = 16;
  localparam int SAMPLE_W = 10;
  localparam int CFG_W    = 4;
  localparam int CFG_LSB  = 12;
  localparam int DATA_LSB = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_HOLD  = 3'd2,
    S_GAP   = 3'd3,
    S_LDAC  = 3'd4
  } state_e;

  // Frame layout: {cfg, sample, 2'b00}; the low bits are DAC don't-cares.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [CFG_W-1:0]    cfg,
                                                    input logic [SAMPLE_W-1:0] s);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[CFG_LSB +: CFG_W]     = cfg;
    f[DATA_LSB +: SAMPLE_W] = s;
    return f;
  endfunction
endpackage

// File: rtl/lfo_dac_tx_if.sv
// Sample input and DAC SPI pins of lfo_dac_tx. The sample producer (or bench)
// uses master; the transmitter uses slave.
interface lfo_dac_tx_if;
  import lfo_dac_tx_pkg::*;

  logic                sample_tick;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sclk;
  logic                mosi;
  logic                cs_n;
  logic                ldac_n;
  logic                busy;
  logic                overrun;

  modport master (output sample_tick, sample_in,
                  input  sclk, mosi, cs_n, ldac_n, busy, overrun);
  modport slave  (input  sample_tick, sample_in,
                  output sclk, mosi, cs_n, ldac_n, busy, overrun);
endinterface

// File: rtl/lfo_dac_tx_spi_bit_timer.sv
// SPI mode-0 bit timer: phase counter, SCLK generator and bit counter.
// While en is low everything is held cleared, so each enable starts a
// fresh frame with SCLK low for the first half bit.
module spi_bit_timer #(
  parameter  int CLK_DIV = 4,
  parameter  int BITS    = 16,
  localparam int BC_W    = $clog2(BITS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  output logic            sclk,
  output logic            rise_tick,
  output logic            fall_tick,
  output logic [BC_W-1:0] bit_cnt,
  output logic            last_bit
);
  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PH_W-1:0] phase;
  logic            ph_end;

  assign ph_end    = (phase == PH_W'(CLK_DIV - 1));
  assign rise_tick = en && ph_end && !sclk;
  assign fall_tick = en && ph_end && sclk;
  assign last_bit  = (bit_cnt == BC_W'(BITS - 1));

  // Half-period phase counter; SCLK flips at each phase wrap, bit advances on the fall.
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      phase   <= '0;
      sclk    <= 1'b0;
      bit_cnt <= '0;
    end else if (ph_end) begin
      phase <= '0;
      sclk  <= ~sclk;
      if (sclk) bit_cnt <= bit_cnt + 1'b1;
    end else begin
      phase <= phase + 1'b1;
    end
  end
endmodule

// File: rtl/lfo_dac_tx.sv
// Serialises 10-bit LFO samples into 16-bit MCP4911-style SPI write frames,
// with a 1-deep pending buffer for samples arriving mid-frame.
// Optional feature macro: LFO_DAC_LDAC_EN adds an LDAC latch pulse after each frame.
module lfo_dac_tx
  import lfo_dac_tx_pkg::*;
#(
  parameter int               CLK_DIV  = 4,
  parameter logic [CFG_W-1:0] CFG_BITS = 4'b0011,
  parameter int               LDAC_W   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  lfo_dac_tx_if.slave bus
);
  localparam int WC_W = $clog2(CLK_DIV + LDAC_W + 1);
  localparam int BC_W = $clog2(FRAME_W);

  state_e              state, state_nx;
  logic [WC_W-1:0]     wait_cnt, wait_nx;
  logic [FRAME_W-1:0]  shreg;
  logic                pend_vld;
  logic [SAMPLE_W-1:0] pend_data;
  logic                exit_now, load_pend;
  logic                rise_tick, fall_tick, last_bit, sclk;
  logic [BC_W-1:0]     bit_cnt;
  logic                cs_n_q, busy_q, ovr_q;

  spi_bit_timer #(.CLK_DIV(CLK_DIV), .BITS(FRAME_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state == S_SHIFT),
    .sclk     (sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .bit_cnt  (bit_cnt),
    .last_bit (last_bit)
  );

  // Next state and wait counter; exit_now marks the last cycle of the frame tail.
  always_comb begin
    state_nx = state;
    exit_now = 1'b0;
    case (state)
      S_IDLE:  if (bus.sample_tick) state_nx = S_SHIFT;
      S_SHIFT: if (fall_tick && last_bit) state_nx = S_HOLD;
      S_HOLD:  if (wait_cnt == WC_W'(CLK_DIV - 1)) state_nx = S_GAP;
      S_GAP:   if (wait_cnt == WC_W'(CLK_DIV - 1)) begin
`ifdef LFO_DAC_LDAC_EN
                 state_nx = S_LDAC;
`else
                 exit_now = 1'b1;
`endif
               end
`ifdef LFO_DAC_LDAC_EN
      S_LDAC:  if (wait_cnt == WC_W'(LDAC_W)) exit_now = 1'b1;
`endif
      default: state_nx = S_IDLE;
    endcase
    if (exit_now) state_nx = pend_vld ? S_SHIFT : S_IDLE;
    load_pend = exit_now && pend_vld;
    if (state_nx != state || state_nx == S_IDLE || state_nx == S_SHIFT) wait_nx = '0;
    else                                                                 wait_nx = wait_cnt + 1'b1;
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  // Shift register: load on frame start, shift on each SCLK fall; zeros fill in so mosi idles low.
  always_ff @(posedge clk) begin
    if (!reset_n)                         shreg <= '0;
    else if (state == S_IDLE && bus.sample_tick) shreg <= make_frame(CFG_BITS, bus.sample_in);
    else if (load_pend)                   shreg <= make_frame(CFG_BITS, pend_data);
    else if (fall_tick)                   shreg <= {shreg[FRAME_W-2:0], 1'b0};
  end

  // Pending buffer: newest sample wins; overwriting an unconsumed sample is sticky overrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
      ovr_q     <= 1'b0;
    end else if (bus.sample_tick && state != S_IDLE) begin
      pend_vld  <= 1'b1;
      pend_data <= bus.sample_in;
      if (pend_vld && !load_pend) ovr_q <= 1'b1;
    end else if (load_pend) begin
      pend_vld <= 1'b0;
    end
  end

  // Registered pin decode from the next state so cs_n/busy are glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      cs_n_q <= !(state_nx == S_SHIFT || state_nx == S_HOLD);
      busy_q <= (state_nx != S_IDLE);
    end
  end

`ifdef LFO_DAC_LDAC_EN
  logic ldac_q;
  // LDAC pulse: low for the first LDAC_W cycles of the LDAC state, then high one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) ldac_q <= 1'b1;
    else          ldac_q <= !(state_nx == S_LDAC && wait_nx < WC_W'(LDAC_W));
  end
  assign bus.ldac_n = ldac_q;
`else
  assign bus.ldac_n = 1'b1;
`endif

  // The timer only runs while shifting, so its rising strobe never appears elsewhere.
  always_ff @(posedge clk) begin
    if (reset_n && rise_tick) assert (state == S_SHIFT);
  end

  assign bus.sclk    = sclk;
  assign bus.mosi    = shreg[FRAME_W-1];
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_lfo_dac_tx.sv
// Bench for lfo_dac_tx: table of single-sample frames plus hand sequences for
// back-to-back, overrun, same-edge pending consume and mid-frame reset.
module tb_lfo_dac_tx;
`ifdef LFO_DAC_LDAC_EN
  localparam int BUSY_CYC = 140;
  localparam int GAP_CYC  = 7;
  localparam int LDAC_EXP = 2;
`else
  localparam int BUSY_CYC = 137;
  localparam int GAP_CYC  = 4;
  localparam int LDAC_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  lfo_dac_tx_if bus();

  lfo_dac_tx dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame monitor (samples on the falling clk edge)
  logic [15:0] frames[$];
  int          lens[$], togs[$], gaps[$];
  logic [15:0] cap;
  int lo_run = 0, hi_run = 0, tog = 0, ldac_lo = 0, ldac_bad = 0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.cs_n === 1'b0) begin
      if (cs_prev) begin
        gaps.push_back(hi_run);
        cap = '0; lo_run = 0; tog = 0;
      end
      lo_run++;
      if (bus.sclk && !sclk_prev) cap = {cap[14:0], bus.mosi};
      if (bus.sclk != sclk_prev) tog++;
      if (!bus.ldac_n) ldac_bad++;
    end else begin
      if (!cs_prev) begin
        frames.push_back(cap); lens.push_back(lo_run); togs.push_back(tog);
        hi_run = 0;
      end
      hi_run++;
      if (!bus.ldac_n) ldac_lo++;
    end
    cs_prev   = bus.cs_n;
    sclk_prev = bus.sclk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    @(posedge clk); #1;
    frames.delete(); lens.delete(); togs.delete(); gaps.delete();
    ldac_lo = 0;
  endtask

  // Tick for exactly one rising edge; returns 1 time unit after that edge.
  task automatic pulse(input logic [9:0] s);
    @(negedge clk);
    bus.sample_tick = 1'b1;
    bus.sample_in   = s;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    bit done = 0;
    cyc = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy) done = 1;
    end
    if (!done) chk("busy_timeout", 1, 0);
  endtask

  function automatic int fr(input int i);
    return (frames.size() > i) ? int'(frames[i]) : -1;
  endfunction

  typedef struct { logic [9:0] s; logic [15:0] f; } vec_t;
  vec_t vt[6];

  task automatic single(input logic [9:0] s, input logic [15:0] f);
    int cyc;
    clr();
    pulse(s);
    wait_idle(400, cyc);
    chk("busy_cycles", cyc, BUSY_CYC);
    chk("n_frames", frames.size(), 1);
    chk("frame", fr(0), int'(f));
    chk("cs_low_len", (lens.size() > 0) ? lens[0] : -1, 132);
    chk("sclk_toggles", (togs.size() > 0) ? togs[0] : -1, 32);
    chk("ldac_low", ldac_lo, LDAC_EXP);
  endtask

  initial begin
    int cyc;
    vt[0] = '{10'h2AA, 16'h3AA8};
    vt[1] = '{10'h000, 16'h3000};
    vt[2] = '{10'h3FF, 16'h3FFC};
    vt[3] = '{10'h155, 16'h3554};
    vt[4] = '{10'h001, 16'h3004};
    vt[5] = '{10'h200, 16'h3800};

    reset_n = 1'b0; bus.sample_tick = 1'b0; bus.sample_in = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_ldac_n", bus.ldac_n, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 6; i++) single(vt[i].s, vt[i].f);
    chk("overrun_after_singles", bus.overrun, 0);

    // A then B mid-frame: back-to-back, no overrun
    clr();
    pulse(10'h2AA);
    repeat (39) @(posedge clk);
    pulse(10'h155);
    wait_idle(800, cyc);
    chk("b2b_n_frames", frames.size(), 2);
    chk("b2b_frame_a", fr(0), 16'h3AA8);
    chk("b2b_frame_b", fr(1), 16'h3554);
    chk("b2b_gap", (gaps.size() > 0) ? gaps[gaps.size()-1] : -1, GAP_CYC);
    chk("b2b_overrun", bus.overrun, 0);

    // A, B, C: B overwritten by C, overrun sticks
    clr();
    pulse(10'h2AA);
    repeat (19) @(posedge clk);
    pulse(10'h155);
    repeat (39) @(posedge clk);
    pulse(10'h0F0);
    wait_idle(800, cyc);
    chk("ovr_n_frames", frames.size(), 2);
    chk("ovr_frame_a", fr(0), 16'h3AA8);
    chk("ovr_frame_c", fr(1), 16'h33C0);
    chk("ovr_set", bus.overrun, 1);
    single(10'h3FF, 16'h3FFC);
    chk("ovr_sticky", bus.overrun, 1);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1;
    chk("ovr_cleared", bus.overrun, 0);
    @(negedge clk) reset_n = 1'b1;

    // Tick on the same edge the pending sample is consumed: no loss, no overrun
    clr();
    pulse(10'h2AA);
    repeat (39) @(posedge clk);
    pulse(10'h155);
    repeat (BUSY_CYC - 42) @(posedge clk);
    pulse(10'h0F0);
    wait_idle(1200, cyc);
    chk("same_n_frames", frames.size(), 3);
    chk("same_frame_a", fr(0), 16'h3AA8);
    chk("same_frame_b", fr(1), 16'h3554);
    chk("same_frame_c", fr(2), 16'h33C0);
    chk("same_overrun", bus.overrun, 0);

    // Reset during bit 7 aborts the frame on the next edge
    clr();
    pulse(10'h2AA);
    repeat (66) @(posedge clk); #1;
    chk("mid_cs_low", bus.cs_n, 0);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs_n", bus.cs_n, 1);
    chk("abort_sclk", bus.sclk, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    single(10'h155, 16'h3554);

    chk("ldac_low_while_cs", ldac_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
